// File: rtl/dmem_store_buffer_responder.sv
// Data-memory responder: one load port and one store port per cycle, a single-ported word
// array, and a FIFO store buffer that drains into the array in cycles without a load.
module dmem_store_buffer_responder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned SB_DEPTH  = 4
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             ld_valid_i,
  input  logic [WIDTH-1:0] ld_addr_i,
  output logic             ld_ready_o,
  output logic             ld_rvalid_o,
  output logic [WIDTH-1:0] ld_rdata_o,
  input  logic             st_valid_i,
  input  logic [WIDTH-1:0] st_addr_i,
  input  logic [WIDTH-1:0] st_data_i,
  output logic             st_ready_o,
  output logic             sb_empty_o
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;
  localparam int unsigned PtrW  = $clog2(SB_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  typedef enum logic {StServe, StDrain} mode_e;

  logic [WIDTH-1:0]     mem_q [Depth];
  logic [ADDR_BITS-1:0] idx_q [SB_DEPTH];
  logic [WIDTH-1:0]     data_q [SB_DEPTH];
  logic [SB_DEPTH-1:0]  valid_q, valid_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  mode_e                mode_q, mode_d;
  logic                 rvalid_q, rvalid_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;

  logic [ADDR_BITS-1:0] ld_idx, st_idx;
  logic                 full, ld_acc, push, drain;
  logic                 fwd_hit;
  logic [WIDTH-1:0]     fwd_data;
  logic [PtrW-1:0]      scan_ptr;

  // Only the word-index bits of the addresses matter.
  assign ld_idx = ld_addr_i[ADDR_BITS+1:2];
  assign st_idx = st_addr_i[ADDR_BITS+1:2];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_addr_i[WIDTH-1:ADDR_BITS+2], ld_addr_i[1:0],
                              st_addr_i[WIDTH-1:ADDR_BITS+2], st_addr_i[1:0]};

  assign full        = (count_q == CntW'(SB_DEPTH));
  assign ld_ready_o  = !full;
  assign st_ready_o  = !full;
  assign sb_empty_o  = (count_q == '0);
  assign ld_rvalid_o = rvalid_q;
  assign ld_rdata_o  = rdata_q;
  assign ld_acc      = ld_valid_i && ld_ready_o;
  assign push        = st_valid_i && st_ready_o;

  // Forwarding scan from oldest to youngest; the last match (youngest) wins.
  // The same-cycle push is not visible here, so a concurrent store never forwards.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    scan_ptr = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      scan_ptr = rd_ptr_q + PtrW'(i);
      if (valid_q[scan_ptr] && (idx_q[scan_ptr] == ld_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[scan_ptr];
      end
    end
  end

  // Array port arbitration and buffer/next-state bookkeeping.
  always_comb begin
    drain    = 1'b0;
    mode_d   = mode_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rvalid_d = ld_acc;
    rdata_d  = rdata_q;
    unique case (mode_q)
      StServe: drain = !ld_acc && (count_q != '0);
      StDrain: drain = 1'b1;
      default: drain = 1'b0;
    endcase
    if (ld_acc) begin
      rdata_d = fwd_hit ? fwd_data : mem_q[ld_idx];
    end
    if (drain) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    count_d = count_q + CntW'(push) - CntW'(drain);
    mode_d  = (count_d == CntW'(SB_DEPTH)) ? StDrain : StServe;
  end

  // Control state; reset discards any buffered stores.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      mode_q   <= StServe;
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      mode_q   <= mode_d;
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Entry payloads and the array are not reset; writes are suppressed during reset.
  always_ff @(posedge clk_i) begin
    if (!clr_i && push) begin
      idx_q[wr_ptr_q]  <= st_idx;
      data_q[wr_ptr_q] <= st_data_i;
    end
    if (!clr_i && drain) begin
      mem_q[idx_q[rd_ptr_q]] <= data_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer_responder.sv
// Directed bench: loads push their expected data into a scoreboard queue, and a monitor pops and
// compares whenever the responder presents load data.
module tb_dmem_store_buffer_responder;

  logic        clk = 1'b0;
  logic        clr;
  logic        ld_valid, st_valid;
  logic [31:0] ld_addr, st_addr, st_data;
  logic        ld_ready, ld_rvalid, st_ready, sb_empty;
  logic [31:0] ld_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_store_buffer_responder #(.WIDTH(32), .ADDR_BITS(6), .SB_DEPTH(4)) dut (
    .clk_i      (clk),
    .clr_i      (clr),
    .ld_valid_i (ld_valid),
    .ld_addr_i  (ld_addr),
    .ld_ready_o (ld_ready),
    .ld_rvalid_o(ld_rvalid),
    .ld_rdata_o (ld_rdata),
    .st_valid_i (st_valid),
    .st_addr_i  (st_addr),
    .st_data_i  (st_data),
    .st_ready_o (st_ready),
    .sb_empty_o (sb_empty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every presented load response must match the oldest expected entry.
  always @(negedge clk) begin
    if (ld_rvalid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rvalid: got data 0x%08h, expected no response", ld_rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (ld_rdata !== e) begin
          n_fail++;
          $display("FAIL load_data: got 0x%08h, expected 0x%08h", ld_rdata, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; an issued load is expected to be accepted and return exp.
  task automatic op(input logic lv, input logic [31:0] la, input logic [31:0] exp,
                    input logic sv, input logic [31:0] sa, input logic [31:0] sd);
    ld_valid = lv; ld_addr = la;
    st_valid = sv; st_addr = sa; st_data = sd;
    if (lv) exp_q.push_back(exp);
    step();
    ld_valid = 1'b0; st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb_empty !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check(name, {31'b0, sb_empty}, 32'h1);
  endtask

  initial begin
    clr = 1'b1; ld_valid = 1'b0; st_valid = 1'b0;
    ld_addr = '0; st_addr = '0; st_data = '0;
    step(); step();
    clr = 1'b0;
    #1;
    // 1: reset state
    check("rst_rvalid",   {31'b0, ld_rvalid}, 32'h0);
    check("rst_rdata",    ld_rdata,           32'h0);
    check("rst_sb_empty", {31'b0, sb_empty},  32'h1);
    check("rst_st_ready", {31'b0, st_ready},  32'h1);
    check("rst_ld_ready", {31'b0, ld_ready},  32'h1);

    // Known array contents for the words used below.
    op(1'b0, 0, 0, 1'b1, 32'h30, 32'h5);
    op(1'b0, 0, 0, 1'b1, 32'h40, 32'h0);
    op(1'b0, 0, 0, 1'b1, 32'h44, 32'h0);
    op(1'b0, 0, 0, 1'b1, 32'h48, 32'h0);
    op(1'b0, 0, 0, 1'b1, 32'h50, 32'h77);
    wait_empty("init_drain");

    // 2: store then load next cycle (forwarded)
    op(1'b0, 0, 0, 1'b1, 32'h10, 32'hDEADBEEF);
    op(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 0, 0);
    wait_empty("t2_drain");
    // Aliased address (upper and byte-offset bits differ) reads the drained word.
    op(1'b1, 32'hFFFF_FF13, 32'hDEADBEEF, 1'b0, 0, 0);

    // 3: youngest-entry forwarding
    op(1'b1, 32'h50, 32'h77, 1'b1, 32'h20, 32'h1);
    op(1'b1, 32'h50, 32'h77, 1'b1, 32'h20, 32'h2);
    op(1'b1, 32'h20, 32'h2,  1'b0, 0, 0);
    wait_empty("t3_drain");

    // 4: same-cycle load and store to one word
    op(1'b1, 32'h30, 32'h5, 1'b1, 32'h30, 32'h9);
    op(1'b0, 0, 0, 1'b0, 0, 0);
    op(1'b1, 32'h30, 32'h9, 1'b0, 0, 0);
    wait_empty("t4_drain");

    // 5: fill the buffer while loads block draining
    for (int k = 0; k < 4; k++)
      op(1'b1, 32'h50, 32'h77, 1'b1, 32'h60 + 32'(4 * k), 32'hA0 + 32'(k));
    check("full_st_ready", {31'b0, st_ready}, 32'h0);
    check("full_ld_ready", {31'b0, ld_ready}, 32'h0);
    check("full_sb_empty", {31'b0, sb_empty}, 32'h0);
    ld_valid = 1'b1; ld_addr = 32'h50;  // refused: no response expected
    step();
    ld_valid = 1'b0;
    check("after_drain_ld_ready", {31'b0, ld_ready}, 32'h1);
    check("after_drain_st_ready", {31'b0, st_ready}, 32'h1);
    wait_empty("t5_drain");
    op(1'b1, 32'h64, 32'hA1, 1'b0, 0, 0);
    op(1'b1, 32'h6C, 32'hA3, 1'b0, 0, 0);

    // 6: reset discards buffered stores
    op(1'b1, 32'h50, 32'h77, 1'b1, 32'h40, 32'h11);
    op(1'b1, 32'h50, 32'h77, 1'b1, 32'h44, 32'h22);
    op(1'b1, 32'h50, 32'h77, 1'b1, 32'h48, 32'h33);
    check("pre_clr_sb_empty", {31'b0, sb_empty}, 32'h0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("post_clr_sb_empty", {31'b0, sb_empty},  32'h1);
    check("post_clr_rvalid",   {31'b0, ld_rvalid}, 32'h0);
    check("post_clr_rdata",    ld_rdata,           32'h0);
    op(1'b1, 32'h40, 32'h0, 1'b0, 0, 0);
    op(1'b1, 32'h44, 32'h0, 1'b0, 0, 0);
    op(1'b1, 32'h48, 32'h0, 1'b0, 0, 0);
    step(); step();

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
